// File: rtl/fighter_core_param.sv
// Per-player fighter core: walking, jump physics, attacks with a one-deep chain
// buffer, hitstun with knockback and combo count, and blocking, stepped per SCEN.
module fighter_core_param #(
  parameter int POS_WIDTH   = 10,
  parameter int NUM_ATTACKS = 4,
  parameter int ATTACK_LEN  = 16,
  parameter int BUFFER_WIN  = 4,
  parameter int START_X     = 100,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 600,
  parameter int WALK_SPEED  = 2,
  parameter int JUMP_V0     = 12,
  parameter int GRAVITY     = 1,
  parameter int HITSTUN_LEN = 20,
  parameter int BLOCK_LEN   = 10,
  parameter int KNOCKBACK   = 1,
  localparam int AT_W = $clog2(NUM_ATTACKS),
  localparam int AF_W = $clog2(ATTACK_LEN)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   SCEN,
  input  logic                   move_left,
  input  logic                   move_right,
  input  logic                   jump,
  input  logic [NUM_ATTACKS-1:0] attack_req,
  input  logic                   hit_in,
  input  logic [POS_WIDTH-1:0]   opponent_x,
  output logic [POS_WIDTH-1:0]   pos_x,
  output logic [POS_WIDTH-1:0]   pos_y,
  output logic                   face_right,
  output logic [2:0]             state,
  output logic                   attack_active,
  output logic [AT_W-1:0]        attack_type,
  output logic [AF_W-1:0]        attack_frame,
  output logic                   blocking,
  output logic [3:0]             combo_count
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, WALK = 3'd1, AIR = 3'd2, ATTACK = 3'd3, HITSTUN = 3'd4, BLOCK = 3'd5
  } state_t;

  // Two guard bits so that a position near the top of the range plus a step never wraps.
  localparam int SW      = POS_WIDTH + 2;
  localparam int CNT_MAX = (HITSTUN_LEN > BLOCK_LEN) ? HITSTUN_LEN : BLOCK_LEN;
  localparam int CW      = $clog2(CNT_MAX + 1);
  typedef logic signed [SW-1:0] sv_t;

  state_t          st, ns;
  logic [POS_WIDTH-1:0] nx, ny;
  sv_t             vy, nvy;
  logic            nface, nblk, nbv, bv;
  logic [AT_W-1:0] ntype, nbt, bt;
  logic [AF_W-1:0] nframe;
  logic [CW-1:0]   cnt, ncnt, cnt_dec;
  logic [3:0]      ncombo;

  function automatic logic [AT_W-1:0] lowest(input logic [NUM_ATTACKS-1:0] r);
    lowest = '0;
    for (int i = NUM_ATTACKS-1; i >= 0; i--)
      if (r[i]) lowest = AT_W'(i);
  endfunction

  function automatic logic [POS_WIDTH-1:0] lo_bits(input sv_t v);
    lo_bits = v[POS_WIDTH-1:0];
  endfunction

  function automatic logic [POS_WIDTH-1:0] clamp_x(input sv_t v);
    if (v < sv_t'(X_MIN))      clamp_x = POS_WIDTH'(X_MIN);
    else if (v > sv_t'(X_MAX)) clamp_x = POS_WIDTH'(X_MAX);
    else                       clamp_x = lo_bits(v);
  endfunction

  logic dir, guard, landed, cap, eff_v;
  logic [AT_W-1:0] eff_t;
  logic [POS_WIDTH-1:0] walk_x, knock_x, phys_y;
  sv_t px_s, y_sum, phys_vy;

  always_comb begin
    dir     = move_left ^ move_right;
    guard   = (st == IDLE || st == WALK) && dir && (move_left ? face_right : !face_right);
    px_s    = $signed({2'b00, pos_x});
    walk_x  = clamp_x(px_s + (move_right ? sv_t'(WALK_SPEED) : -sv_t'(WALK_SPEED)));
    knock_x = clamp_x(px_s + (face_right ? -sv_t'(KNOCKBACK) : sv_t'(KNOCKBACK)));
    y_sum   = $signed({2'b00, pos_y}) + vy;
    landed  = (y_sum <= sv_t'(0));
    phys_y  = landed ? '0 : lo_bits(y_sum);
    phys_vy = landed ? '0 : vy - sv_t'(GRAVITY);
    cnt_dec = (cnt != '0) ? cnt - 1'b1 : '0;
    // A request on the final frame still chains: treat it as already buffered.
    cap     = !bv && (|attack_req) && (int'(attack_frame) >= ATTACK_LEN - BUFFER_WIN);
    eff_v   = bv | cap;
    eff_t   = bv ? bt : lowest(attack_req);
  end

  always_comb begin
    ns = st; nx = pos_x; ny = pos_y; nvy = vy; nface = face_right;
    ntype = attack_type; nframe = attack_frame; ncnt = cnt; ncombo = combo_count;
    nbv = bv; nbt = bt;
    if (st == IDLE || st == WALK || st == BLOCK) begin
      if (opponent_x > pos_x)      nface = 1'b1;
      else if (opponent_x < pos_x) nface = 1'b0;
    end
    if (hit_in) begin
      if (guard) begin
        ns = BLOCK; ncnt = CW'(BLOCK_LEN);
      end else if (st == HITSTUN) begin
        ncnt = CW'(HITSTUN_LEN);
        if (combo_count != 4'd15) ncombo = combo_count + 4'd1;
      end else begin
        ns = HITSTUN; ncnt = CW'(HITSTUN_LEN); ncombo = 4'd1; nframe = '0; nbv = 1'b0;
      end
    end else begin
      case (st)
        IDLE, WALK: begin
          if (|attack_req) begin
            ns = ATTACK; ntype = lowest(attack_req); nframe = '0;
          end else if (jump) begin
            ns = AIR; nvy = sv_t'(JUMP_V0);
          end else if (dir) begin
            ns = WALK; nx = walk_x;
          end else begin
            ns = IDLE;
          end
        end
        AIR: begin
          ny = phys_y; nvy = phys_vy;
          if (landed) ns = IDLE;
          if (dir) nx = walk_x;
        end
        ATTACK: begin
          if (int'(attack_frame) == ATTACK_LEN - 1) begin
            nframe = '0; nbv = 1'b0;
            if (eff_v) ntype = eff_t;
            else       ns = IDLE;
          end else begin
            nframe = attack_frame + 1'b1;
            if (cap) begin nbv = 1'b1; nbt = lowest(attack_req); end
          end
        end
        HITSTUN: begin
          nx = knock_x;
          if (pos_y != '0) begin ny = phys_y; nvy = phys_vy; end
          else nvy = '0;
          ncnt = cnt_dec;
          if (cnt_dec == '0 && ny == '0) begin ns = IDLE; ncombo = 4'd0; end
        end
        BLOCK: begin
          ncnt = cnt_dec;
          if (cnt_dec == '0) ns = IDLE;
        end
        default: ns = IDLE;
      endcase
    end
    nblk = (ns == BLOCK) ||
           ((ns == IDLE || ns == WALK) && dir && (move_left ? nface : !nface));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE; pos_x <= POS_WIDTH'(START_X); pos_y <= '0; vy <= '0;
      face_right <= 1'b1; attack_type <= '0; attack_frame <= '0; cnt <= '0;
      combo_count <= 4'd0; bv <= 1'b0; bt <= '0; attack_active <= 1'b0; blocking <= 1'b0;
    end else if (SCEN) begin
      st <= ns; pos_x <= nx; pos_y <= ny; vy <= nvy;
      face_right <= nface; attack_type <= ntype; attack_frame <= nframe; cnt <= ncnt;
      combo_count <= ncombo; bv <= nbv; bt <= nbt;
      attack_active <= (ns == ATTACK); blocking <= nblk;
    end
  end

  assign state = st;
endmodule

// File: tb/tb_fighter_core_param.sv
// Directed bench for fighter_core_param: table of frame vectors plus hand-written
// sequences for clamping, attack chaining, hitstun, air hits, reset and blocking.
module tb_fighter_core_param;
  logic clk = 1'b0, reset = 1'b1, scen = 1'b0;
  logic ml = 1'b0, mr = 1'b0, jmp = 1'b0, hit = 1'b0;
  logic [3:0] req = '0;
  logic [9:0] opx = 10'd300;
  logic [9:0] pos_x, pos_y;
  logic face_right, attack_active, blocking;
  logic [2:0] state;
  logic [1:0] attack_type;
  logic [3:0] attack_frame, combo_count;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  fighter_core_param dut (
    .clk(clk), .reset(reset), .SCEN(scen), .move_left(ml), .move_right(mr), .jump(jmp),
    .attack_req(req), .hit_in(hit), .opponent_x(opx), .pos_x(pos_x), .pos_y(pos_y),
    .face_right(face_right), .state(state), .attack_active(attack_active),
    .attack_type(attack_type), .attack_frame(attack_frame), .blocking(blocking),
    .combo_count(combo_count)
  );

  task automatic tick(input bit s);
    @(negedge clk); scen = s;
    @(posedge clk); #1; scen = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic scen, ml, mr, jmp;
    logic [3:0] req;
    logic hit;
    int opx, rep;
    int ex, ey, est, ecombo, eblk;
  } vec_t;
  vec_t tbl[13];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 300, 1,  100, 0,  2, 0, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 300, 1,  100, 12, 2, 0, 0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 300, 11, 100, 78, 2, 0, 0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 300, 12, 100, 12, 2, 0, 0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 300, 1,  100, 0,  0, 0, 0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 300, 5,  100, 0,  0, 0, 0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 300, 3,  106, 0,  1, 0, 0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 300, 1,  106, 0,  0, 0, 0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 300, 1,  104, 0,  1, 0, 1};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 300, 1,  104, 0,  2, 0, 0};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 300, 1,  106, 12, 2, 0, 0};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 300, 24, 154, 0,  0, 0, 0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 300, 1,  154, 0,  0, 0, 0};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst x", pos_x, 100);      chk("rst y", pos_y, 0);
    chk("rst state", state, 0);    chk("rst face", face_right, 1);
    chk("rst combo", combo_count, 0); chk("rst type", attack_type, 0);
    chk("rst frame", attack_frame, 0); chk("rst active", attack_active, 0);
    chk("rst blk", blocking, 0);

    foreach (tbl[i]) begin
      ml = tbl[i].ml; mr = tbl[i].mr; jmp = tbl[i].jmp; req = tbl[i].req;
      hit = tbl[i].hit; opx = 10'(tbl[i].opx);
      repeat (tbl[i].rep) tick(tbl[i].scen);
      chk($sformatf("row%0d x", i), pos_x, tbl[i].ex);
      chk($sformatf("row%0d y", i), pos_y, tbl[i].ey);
      chk($sformatf("row%0d state", i), state, tbl[i].est);
      chk($sformatf("row%0d combo", i), combo_count, tbl[i].ecombo);
      chk($sformatf("row%0d blk", i), blocking, tbl[i].eblk);
    end
    ml = 0; mr = 0; jmp = 0; req = '0; hit = 0;

    // right clamp, both-direction cancel, frozen while SCEN low
    opx = 10'd700; mr = 1;
    repeat (222) tick(1);
    chk("walk x598", pos_x, 598);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      chk($sformatf("clamp%0d x", k), pos_x, 600);
    end
    ml = 1; tick(1);
    chk("both state", state, 0); chk("both x", pos_x, 600);
    ml = 0; jmp = 1; hit = 1; req = 4'b0001;
    repeat (5) tick(0);
    chk("hold x", pos_x, 600); chk("hold state", state, 0);
    chk("hold combo", combo_count, 0);
    mr = 0; jmp = 0; hit = 0; req = '0;

    opx = 10'd0;   tick(1); chk("face left", face_right, 0);
    opx = 10'd900; tick(1); chk("face right", face_right, 1);

    // attack with a buffered chain
    req = 4'b0110; tick(1);
    chk("atk state", state, 3); chk("atk type", attack_type, 1);
    chk("atk frame0", attack_frame, 0); chk("atk active", attack_active, 1);
    for (int f = 0; f < 15; f++) begin
      req = (f == 11) ? 4'b0001 : (f == 13) ? 4'b1000 : (f == 14) ? 4'b0001 : 4'b0000;
      tick(1);
      chk($sformatf("atk f%0d", f + 1), attack_frame, f + 1);
      chk($sformatf("atk st f%0d", f + 1), state, 3);
    end
    req = '0; tick(1);
    chk("chain state", state, 3); chk("chain type", attack_type, 3);
    chk("chain frame", attack_frame, 0);
    repeat (15) tick(1);
    chk("chain f15", attack_frame, 15);
    tick(1);
    chk("atk end state", state, 0); chk("atk end active", attack_active, 0);
    chk("atk end x", pos_x, 600);

    // hit during attack, then a second hit in hitstun
    req = 4'b0001; tick(1); req = '0;
    repeat (5) tick(1);
    chk("pre-hit frame", attack_frame, 5);
    hit = 1; tick(1); hit = 0;
    chk("hit state", state, 4); chk("hit active", attack_active, 0);
    chk("hit combo", combo_count, 1); chk("hit x", pos_x, 600);
    tick(1); chk("knock1 x", pos_x, 599);
    repeat (9) tick(1);
    chk("knock10 x", pos_x, 590); chk("knock10 state", state, 4);
    hit = 1; tick(1); hit = 0;
    chk("hit2 combo", combo_count, 2); chk("hit2 x", pos_x, 590);
    repeat (19) tick(1);
    chk("stun19 state", state, 4); chk("stun19 x", pos_x, 571);
    chk("stun19 combo", combo_count, 2);
    tick(1);
    chk("stun end state", state, 0); chk("stun end combo", combo_count, 0);
    chk("stun end x", pos_x, 570);

    // hit in the air: counter expires before landing
    jmp = 1; tick(1); jmp = 0;
    repeat (3) tick(1);
    chk("air3 y", pos_y, 33);
    hit = 1; tick(1); hit = 0;
    chk("air hit state", state, 4); chk("air hit y", pos_y, 33);
    chk("air hit combo", combo_count, 1);
    repeat (20) tick(1);
    chk("air stun20 state", state, 4); chk("air stun20 y", pos_y, 23);
    tick(1);
    chk("air stun21 state", state, 4); chk("air stun21 y", pos_y, 12);
    tick(1);
    chk("land state", state, 0); chk("land y", pos_y, 0);
    chk("land combo", combo_count, 0); chk("land x", pos_x, 548);

    // reset while walking, with SCEN high
    mr = 1; repeat (2) tick(1);
    chk("pre-rst x", pos_x, 552);
    reset = 1; tick(1); reset = 0; mr = 0;
    chk("mid rst x", pos_x, 100); chk("mid rst state", state, 0);
    chk("mid rst face", face_right, 1); chk("mid rst combo", combo_count, 0);

    // block, then an unguarded hit while in blockstun
    opx = 10'd300; ml = 1; hit = 1; tick(1); hit = 0;
    chk("blk state", state, 5); chk("blk out", blocking, 1);
    chk("blk x", pos_x, 100); chk("blk combo", combo_count, 0);
    repeat (9) tick(1);
    chk("blk9 state", state, 5); chk("blk9 x", pos_x, 100); chk("blk9 out", blocking, 1);
    tick(1);
    chk("blk end state", state, 0); chk("blk end x", pos_x, 100);
    chk("blk end combo", combo_count, 0);
    hit = 1; tick(1);
    chk("reblk state", state, 5);
    ml = 0; tick(1); hit = 0;
    chk("blk->stun state", state, 4); chk("blk->stun combo", combo_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
